// File: rtl/dark_pipe_pkg.sv
// Shared definitions for the pipe_reg_chain register pipeline.
// Provides the occupancy counter width and the default stage reset fill.
package dark_pipe_pkg;

    localparam logic DEFAULT_RESET_BIT = 1'b0;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid flag plus data register with load/hold/bubble/reset.
// Data only loads when the upstream word is valid, so bubbles never disturb it.
module pipe_stage
    import dark_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (adv) begin
            vld_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VALUE;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse and occupancy count.
// Optional synchronous flush input enabled by defining DARKC_PIPE_FLUSH_EN.
module pipe_reg_chain
    import dark_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [count_width(DEPTH)-1:0]     count
`ifdef DARKC_PIPE_FLUSH_EN
    ,
    input  logic                              flush
`endif
);

    localparam int unsigned CNT_W = count_width(DEPTH);

    if (DEPTH == 0) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be at least 1");
    end

    logic                 flush_i;
    logic [DEPTH-1:0]     vld;
    logic [WIDTH-1:0]     data [DEPTH];
    logic [DEPTH:0]       rdy;
    logic                 in_fire, out_fire;
    logic [CNT_W-1:0]     count_q, count_d;

`ifdef DARKC_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // A stage can take new data if it is empty or its own content moves on.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            rdy[i-1] = !vld[i-1] || rdy[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = vld[i-1];
            assign up_d = data[i-1];
        end
        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush_i),
            .adv     (rdy[i]),
            .up_valid(up_v),
            .up_data (up_d),
            .vld     (vld[i]),
            .data    (data[i])
        );
    end

    assign in_ready  = rdy[0] && !flush_i;
    assign out_valid = vld[DEPTH-1] && !flush_i;
    assign out_data  = data[DEPTH-1];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
// Item-queue reference model checked every cycle plus directed literal checks.
module tb_pipe_reg_chain;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 3;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] count;
    logic       flush_s = 1'b0;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH      (W),
        .DEPTH      (D),
        .RESET_VALUE(RV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
`ifdef DARKC_PIPE_FLUSH_EN
        ,
        .flush    (flush_s)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: in-flight items, oldest first, each with its stage position.
    int unsigned m_pos[$];
    logic [7:0]  m_dat[$];
    logic [7:0]  m_last = RV;
    bit          m_mv[D];

    // Decides which items move this cycle; returns whether a new item is accepted.
    function automatic bit m_plan();
        int n = m_pos.size();
        for (int k = 0; k < n; k++) begin
            if (k == 0) m_mv[k] = (m_pos[0] == D - 1) ? out_ready : 1'b1;
            else        m_mv[k] = (m_pos[k] + 1 != m_pos[k-1]) || m_mv[k-1];
        end
        if (flush_s) return 1'b0;
        return (n == 0) || (m_pos[n-1] != 0) || m_mv[n-1];
    endfunction

    task automatic m_step();
        int unsigned np[$];
        logic [7:0]  nd[$];
        bit          ir;
        if (rst) begin
            m_pos.delete(); m_dat.delete(); m_last = RV;
            return;
        end
        if (flush_s) begin
            m_pos.delete(); m_dat.delete();
            return;
        end
        ir = m_plan();
        for (int k = 0; k < m_pos.size(); k++) begin
            if (!m_mv[k]) begin
                np.push_back(m_pos[k]); nd.push_back(m_dat[k]);
            end else if (m_pos[k] != D - 1) begin
                np.push_back(m_pos[k] + 1); nd.push_back(m_dat[k]);
                if (m_pos[k] + 1 == D - 1) m_last = m_dat[k];
            end
        end
        if (in_valid && ir) begin
            np.push_back(0); nd.push_back(in_data);
            if (D == 1) m_last = in_data;
        end
        m_pos = np;
        m_dat = nd;
    endtask

    always @(posedge clk) m_step();

    always @(negedge clk) begin
        if (chk_en) begin
            bit eir, eov;
            eir = m_plan();
            eov = (m_pos.size() > 0) && (m_pos[0] == D - 1) && !flush_s;
            chk("m_in_ready",  in_ready,  eir);
            chk("m_out_valid", out_valid, eov);
            chk("m_out_data",  out_data,  m_last);
            chk("m_count",     count,     m_pos.size());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        step();
        chk_en = 1'b1;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  8'hA5);
        chk("rst_count",     count,     0);
        chk("rst_in_ready",  in_ready,  1);
        rst = 1'b0;

        // Streaming 01..0A
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = i[7:0];
            step();
            if (i >= 3) begin
                chk("stream_data",  out_data,  i - 2);
                chk("stream_valid", out_valid, 1);
                chk("stream_count", count,     3);
            end
        end
        in_valid = 1'b0;
        in_data  = 'x;
        step(); step(); step();
        chk("drain_valid", out_valid, 0);
        chk("drain_count", count,     0);
        chk("drain_data",  out_data,  8'h0A);

        // Backpressure and collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h10 + i[7:0];
            step();
        end
        in_data = 8'h13;
        #1;
        chk("bp_count",    count,    3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_data", out_data, 8'h10);
        step();
        chk("bp_hold_count", count,    3);
        chk("bp_hold_data",  out_data, 8'h10);
        out_ready = 1'b1;
        step();
        chk("bp_pass_count", count,    3);
        chk("bp_pass_data",  out_data, 8'h11);
        in_valid = 1'b0;
        in_data  = 'x;
        step(); step(); step();
        chk("bp_drain_count", count, 0);

        // Bubbles 20, gap, 21 under stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h20; step();
        in_valid = 1'b0; in_data = 'x;    step();
        in_valid = 1'b1; in_data = 8'h21; step();
        in_valid = 1'b0; in_data = 'x;    step();
        chk("bub_count",     count,     2);
        chk("bub_out_valid", out_valid, 1);
        chk("bub_out_data",  out_data,  8'h20);
        out_ready = 1'b1;
        step();
        chk("bub_rel1_data",  out_data,  8'h21);
        chk("bub_rel1_valid", out_valid, 1);
        step();
        chk("bub_rel2_valid", out_valid, 0);
        chk("bub_rel2_data",  out_data,  8'h21);

        // Mid-stream reset
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h30; step();
        in_data = 8'h31; step();
        in_valid = 1'b0; in_data = 'x; step();
        chk("mrst_pre_count", count, 2);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h32; out_ready = 1'b1;
        step();
        chk("mrst_count",     count,     0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data",  out_data,  8'hA5);
        chk("mrst_in_ready",  in_ready,  1);
        rst = 1'b0; in_valid = 1'b0; in_data = 'x;
        step();

`ifdef DARKC_PIPE_FLUSH_EN
        // Flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h40 + i[7:0];
            step();
        end
        chk("fl_pre_count", count, 3);
        flush_s = 1'b1; in_data = 8'h43;
        #1;
        chk("fl_in_ready",  in_ready,  0);
        chk("fl_out_valid", out_valid, 0);
        step();
        flush_s = 1'b0; in_valid = 1'b0; in_data = 'x;
        #1;
        chk("fl_count",     count,     0);
        chk("fl_out_data",  out_data,  8'h40);
        chk("fl_out_valid2", out_valid, 0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        step();
        in_valid = 1'b0; in_data = 'x;
        step();
        chk("fl_lat_early", out_valid, 0);
        step();
        chk("fl_lat_valid", out_valid, 1);
        chk("fl_lat_data",  out_data,  8'h44);
        step();
`endif

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step(); step();
        chk("final_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
